chacha_qr_serial: RTL and testbench

Byte-serial ChaCha quarter-round engine for the chacha-block tile. Accepts four 32-bit words (a, b, c, d) over an 8-bit valid/ready stream and applies the RFC 7539 quarter-round ITERATIONS times, one ARX step per cycle. Optionally adds the input words back (ChaCha feed-forward) and streams the 16-byte result out over an 8-bit valid/ready stream. It sits between the tile's pin-level byte interface and the block-function sequencing logic.

---
 rtl/chacha_qr_serial.sv | 127 ++++++++++++
 tb/tb_chacha_qr_serial.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_qr_serial.sv
// Byte-serial ChaCha quarter-round engine: loads a,b,c,d as 16 little-endian bytes,
// runs ITERATIONS quarter-rounds one ARX step per cycle, optional feed-forward, drains 16 bytes.
module chacha_qr_serial #(
  parameter int ITERATIONS  = 1,
  parameter int FEEDFORWARD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {LOAD, COMPUTE, ADD, DRAIN} state_t;

  localparam logic [9:0] LAST_STEP = 10'(4 * ITERATIONS - 1);

  state_t      state, state_nxt;
  logic [3:0]  byte_cnt;
  logic [9:0]  step_cnt;
  logic [31:0] w      [4];
  logic [31:0] ff_sum [4];
  logic [31:0] sa, sb, sc, sd, t;
  logic        in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (in_xfer && byte_cnt == 4'd15) state_nxt = COMPUTE;
      COMPUTE: if (step_cnt == LAST_STEP) state_nxt = (FEEDFORWARD != 0) ? ADD : DRAIN;
      ADD:     state_nxt = DRAIN;
      DRAIN:   if (out_xfer && byte_cnt == 4'd15) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    busy      = (state != LOAD);
    out_data  = '0;
    if (state == DRAIN) out_data = w[byte_cnt[3:2]][{byte_cnt[1:0], 3'b000} +: 8];
  end

  // One ARX step of the quarter-round, selected by the low two step-counter bits.
  always_comb begin
    sa = w[0];
    sb = w[1];
    sc = w[2];
    sd = w[3];
    t  = '0;
    unique case (step_cnt[1:0])
      2'd0: begin sa = w[0] + w[1]; t = w[3] ^ sa; sd = {t[15:0], t[31:16]}; end
      2'd1: begin sc = w[2] + w[3]; t = w[1] ^ sc; sb = {t[19:0], t[31:20]}; end
      2'd2: begin sa = w[0] + w[1]; t = w[3] ^ sa; sd = {t[23:0], t[31:24]}; end
      2'd3: begin sc = w[2] + w[3]; t = w[1] ^ sc; sb = {t[24:0], t[31:25]}; end
    endcase
  end

  // The byte counter serves both the load and the drain; it wraps to 0 after each 16th transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      step_cnt <= '0;
      for (int unsigned i = 0; i < 4; i++) w[i] <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          step_cnt <= '0;
          if (in_xfer) begin
            w[byte_cnt[3:2]][{byte_cnt[1:0], 3'b000} +: 8] <= in_data;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        COMPUTE: begin
          w[0]     <= sa;
          w[1]     <= sb;
          w[2]     <= sc;
          w[3]     <= sd;
          step_cnt <= step_cnt + 10'd1;
        end
        ADD: begin
          for (int unsigned i = 0; i < 4; i++) w[i] <= ff_sum[i];
        end
        DRAIN: begin
          if (out_xfer) byte_cnt <= byte_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  generate
    if (FEEDFORWARD != 0) begin : g_ff
      logic [31:0] w_copy [4];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < 4; i++) w_copy[i] <= '0;
        end else if (in_xfer) begin
          w_copy[byte_cnt[3:2]][{byte_cnt[1:0], 3'b000} +: 8] <= in_data;
        end
      end

      always_comb begin
        for (int unsigned i = 0; i < 4; i++) ff_sum[i] = w[i] + w_copy[i];
      end
    end else begin : g_no_ff
      always_comb begin
        for (int unsigned i = 0; i < 4; i++) ff_sum[i] = w[i];
      end
    end
  endgenerate

endmodule

// File: tb/tb_chacha_qr_serial.sv
// Randomized scoreboard bench for chacha_qr_serial across three configurations
// (1 round raw, 1 round feed-forward, 2 rounds raw) against a plain quarter-round model.
module tb_chacha_qr_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, busy;
  logic [23:0] in_data, out_data;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  q[$];
  int          act = 0;

  always #5 clk = ~clk;

  chacha_qr_serial #(.ITERATIONS(1), .FEEDFORWARD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[7:0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0]));
  chacha_qr_serial #(.ITERATIONS(1), .FEEDFORWARD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[15:8]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[15:8]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1]));
  chacha_qr_serial #(.ITERATIONS(2), .FEEDFORWARD(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[23:16]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_data(out_data[23:16]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .busy(busy[2]));

  function automatic int it_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int ff_of(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] x, input int it, input int ff);
    logic [31:0] v[4];
    logic [31:0] o[4];
    for (int i = 0; i < 4; i++) begin
      v[i] = x[32*i +: 32];
      o[i] = v[i];
    end
    for (int r = 0; r < it; r++) begin
      v[0] = v[0] + v[1]; v[3] = rl(v[3] ^ v[0], 16);
      v[2] = v[2] + v[3]; v[1] = rl(v[1] ^ v[2], 12);
      v[0] = v[0] + v[1]; v[3] = rl(v[3] ^ v[0], 8);
      v[2] = v[2] + v[3]; v[1] = rl(v[1] ^ v[2], 7);
    end
    if (ff != 0) for (int i = 0; i < 4; i++) v[i] = v[i] + o[i];
    return {v[3], v[2], v[1], v[0]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, actual, expected);
    end
  endtask

  // Scoreboard: every valid output byte must equal the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        chk("in_ready_vs_busy", in_ready[k], busy[k] ? 1'b0 : 1'b1);
        if (out_valid[k] === 1'b1) begin
          if (k != act || q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid inst %0d: got out_valid=1 expected 0", k);
          end else begin
            chk($sformatf("out_byte_inst%0d", k), out_data[k*8 +: 8], q[0]);
            if (out_ready[k]) void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic load_bytes(input int k, input logic [127:0] data, input int n, input bit rnd);
    int idx = 0;
    int guard = 0;
    bit xfer;
    while (idx < n && guard < 2000) begin
      in_valid[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data[k*8 +: 8] = data[idx*8 +: 8];
      @(negedge clk);
      xfer = in_valid[k] & in_ready[k];
      @(posedge clk);
      #1;
      if (xfer) idx++;
      guard++;
    end
    if (idx < n) chk("load_timeout", idx, n);
    in_valid[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    in_data[k*8 +: 8] = 8'($urandom);
  endtask

  task automatic wait_out(input int k, input bit rnd);
    int n = 0;
    out_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid[k] !== 1'b1 && n < 3000);
    chk($sformatf("latency_inst%0d", k), n, 4 * it_of(k) + ff_of(k) + 1);
  endtask

  task automatic drain(input int k, input int remain, input bit rnd);
    int guard = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() <= remain || guard >= 3000) break;
      out_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        in_valid[k] = 1'($urandom_range(0, 1));
        in_data[k*8 +: 8] = 8'($urandom);
      end
      guard++;
    end
    if (guard >= 3000) chk("drain_timeout", q.size(), remain);
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
  endtask

  task automatic run_job(input int k, input logic [127:0] data, input logic [127:0] expected, input bit rnd);
    act = k;
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(expected[i*8 +: 8]);
    load_bytes(k, data, 16, rnd);
    wait_out(k, rnd);
    drain(k, 0, rnd);
    @(negedge clk);
    chk("b2b_in_ready", in_ready[k], 1'b1);
    chk("b2b_busy", busy[k], 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    @(posedge clk);
    #1;
    q.delete();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", in_ready[k], 1'b1);
      chk("rst_out_valid", out_valid[k], 1'b0);
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_out_data", out_data[k*8 +: 8], 8'h00);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] vec, r1, rff, ones, d, e;
    int k, sel;
    vec  = pk(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567);
    r1   = pk(32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb);
    rff  = pk(32'hfb3ba405, 32'hcc1efbd2, 32'he10eb671, 32'h59a50a22);
    ones = '1;

    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    in_data = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset_chk();

    chk("model_rfc", model(vec, 1, 0), r1);
    chk("model_rfc_ff", model(vec, 1, 1), rff);
    chk("model_zero", model('0, 1, 0), 128'h0);

    run_job(0, vec, r1, 1'b0);
    run_job(1, vec, rff, 1'b0);
    run_job(2, vec, model(vec, 2, 0), 1'b0);
    run_job(0, '0, 128'h0, 1'b0);
    run_job(0, ones, model(ones, 1, 0), 1'b0);
    run_job(1, ones, model(ones, 1, 1), 1'b0);

    // Reset mid-load, mid-compute and mid-drain; each followed by a clean job.
    act = 0;
    load_bytes(0, vec, 7, 1'b0);
    reset_chk();
    run_job(0, vec, r1, 1'b0);

    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(r1[i*8 +: 8]);
    load_bytes(0, vec, 16, 1'b0);
    @(posedge clk);
    #1;
    reset_chk();
    run_job(0, vec, r1, 1'b0);

    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(r1[i*8 +: 8]);
    load_bytes(0, vec, 16, 1'b0);
    wait_out(0, 1'b0);
    drain(0, 11, 1'b0);
    reset_chk();
    run_job(0, vec, r1, 1'b0);

    for (int j = 0; j < 20; j++) begin
      k = $urandom_range(0, 2);
      sel = $urandom_range(0, 5);
      if (sel == 0) d = '0;
      else if (sel == 1) d = ones;
      else d = {$urandom, $urandom, $urandom, $urandom};
      e = model(d, it_of(k), ff_of(k));
      run_job(k, d, e, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
